// File: rtl/int_dispatch_ctrl_pkg.sv
// Shared constants and types for the interrupt controller / dispatch sequencer.
package int_dispatch_ctrl_pkg;

    localparam int unsigned NUM_IRQ           = 5;
    localparam int unsigned PRIO_W            = 3;
    localparam int unsigned DISPATCH_WAIT_DEF = 2;

    localparam logic [3:0] PC_SEL_HOLD = 4'd0;
    localparam logic [3:0] PC_SEL_ZERO = 4'd4;
    localparam logic [3:0] PC_SEL_INT  = 4'd8;

    // Unimplemented IF bits read back as 1
    localparam logic [7:0] IF_RO_MASK = 8'hE0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_PUSH_HI,
        ST_PUSH_LO,
        ST_JUMP
    } disp_state_e;

endpackage

// File: rtl/int_dispatch_ctrl_prio_enc.sv
// Lowest-set-bit priority encoder over the pending interrupt requests.
module int_prio_enc
    import int_dispatch_ctrl_pkg::*;
(
    input  logic [NUM_IRQ-1:0] req,
    output logic [PRIO_W-1:0]  prio_c,
    output logic               valid_c
);

    always_comb begin
        prio_c  = '0;
        valid_c = 1'b0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (req[i] && !valid_c) begin
                prio_c  = PRIO_W'(i);
                valid_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_dispatch_ctrl.sv
// Interrupt controller: IE/IF/IME state, priority resolution and the
// dispatch sequence that pushes the PC and redirects it to the vector.
module int_dispatch_ctrl
    import int_dispatch_ctrl_pkg::*;
#(
    parameter int unsigned DISPATCH_WAIT = DISPATCH_WAIT_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               ie_wr,
    input  logic               if_wr,
    input  logic [7:0]         reg_wdata,
    output logic [7:0]         ie_out,
    output logic [7:0]         if_out,
    input  logic               ei_exec,
    input  logic               di_exec,
    input  logic               reti_exec,
    input  logic               instr_boundary,
    input  logic [15:0]        pc_in,
    output logic               push_req,
    output logic [7:0]         push_data,
    input  logic               push_ack,
    output logic               pc_sel_ovr_en,
    output logic [3:0]         pc_sel_ovr,
    output logic [PRIO_W-1:0]  int_active_prio,
    output logic               dispatch_busy,
    output logic               int_pending,
    output logic               ime_out
);

    localparam int unsigned WAIT_W = (DISPATCH_WAIT > 1) ? $clog2(DISPATCH_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_INIT =
        (DISPATCH_WAIT > 0) ? WAIT_W'(DISPATCH_WAIT - 1) : '0;

    disp_state_e        state_q, state_nxt;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_nxt;
    logic [15:0]        pc_lat_q, pc_lat_nxt;
    logic               vec_ok_q, vec_ok_nxt;
    logic [NUM_IRQ-1:0] if_q, if_nxt;
    logic [7:0]         ie_nxt;
    logic               ime_nxt, ei_pend_q, ei_pend_nxt;
    logic [PRIO_W-1:0]  prio_nxt;
    logic [NUM_IRQ-1:0] clr_mask;
    logic               accept;

    logic [NUM_IRQ-1:0] req;
    logic [PRIO_W-1:0]  req_prio_c;
    logic               req_valid_c;

    logic               push_req_nxt, pc_sel_ovr_en_nxt;
    logic [7:0]         push_data_nxt;
    logic [3:0]         pc_sel_ovr_nxt;

    assign req    = ie_out[NUM_IRQ-1:0] & if_q;
    assign if_out = IF_RO_MASK | 8'(if_q);

    int_prio_enc u_prio_enc (
        .req     (req),
        .prio_c  (req_prio_c),
        .valid_c (req_valid_c)
    );

    // Next-state, register update and next-output logic
    always_comb begin
        state_nxt    = state_q;
        wait_cnt_nxt = wait_cnt_q;
        pc_lat_nxt   = pc_lat_q;
        vec_ok_nxt   = vec_ok_q;
        prio_nxt     = int_active_prio;
        clr_mask     = '0;
        accept       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (instr_boundary && ime_out && req_valid_c) begin
                    accept       = 1'b1;
                    prio_nxt     = req_prio_c;
                    pc_lat_nxt   = pc_in;
                    wait_cnt_nxt = WAIT_INIT;
                    state_nxt    = (DISPATCH_WAIT == 0) ? ST_PUSH_HI : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == '0) begin
                    state_nxt = ST_PUSH_HI;
                end else begin
                    wait_cnt_nxt = wait_cnt_q - WAIT_W'(1);
                end
            end
            ST_PUSH_HI: begin
                if (push_ack) begin
                    vec_ok_nxt = req[int_active_prio];
                    state_nxt  = ST_PUSH_LO;
                end
            end
            ST_PUSH_LO: begin
                if (push_ack) begin
                    state_nxt = ST_JUMP;
                end
            end
            ST_JUMP: begin
                if (vec_ok_q) begin
                    clr_mask = NUM_IRQ'(1) << int_active_prio;
                end
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // EI takes effect one boundary late; DI always wins
        ime_nxt     = ime_out;
        ei_pend_nxt = ei_pend_q;
        if (ei_pend_q && instr_boundary) begin
            ime_nxt     = 1'b1;
            ei_pend_nxt = 1'b0;
        end
        if (ei_exec)   ei_pend_nxt = 1'b1;
        if (reti_exec) ime_nxt     = 1'b1;
        if (accept || di_exec) begin
            ime_nxt     = 1'b0;
            ei_pend_nxt = 1'b0;
        end

        ie_nxt = ie_wr ? reg_wdata : ie_out;
        if_nxt = ((if_wr ? reg_wdata[NUM_IRQ-1:0] : if_q) & ~clr_mask) | irq_in;

        push_req_nxt      = (state_nxt == ST_PUSH_HI) || (state_nxt == ST_PUSH_LO);
        push_data_nxt     = (state_nxt == ST_PUSH_HI) ? pc_lat_nxt[15:8] :
                            (state_nxt == ST_PUSH_LO) ? pc_lat_nxt[7:0]  : 8'h00;
        pc_sel_ovr_en_nxt = (state_nxt == ST_JUMP);
        pc_sel_ovr_nxt    = (state_nxt != ST_JUMP) ? PC_SEL_HOLD :
                            (vec_ok_nxt ? PC_SEL_INT : PC_SEL_ZERO);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            wait_cnt_q      <= '0;
            pc_lat_q        <= '0;
            vec_ok_q        <= 1'b0;
            if_q            <= '0;
            ie_out          <= '0;
            ime_out         <= 1'b0;
            ei_pend_q       <= 1'b0;
            int_active_prio <= '0;
            push_req        <= 1'b0;
            push_data       <= '0;
            pc_sel_ovr_en   <= 1'b0;
            pc_sel_ovr      <= PC_SEL_HOLD;
            dispatch_busy   <= 1'b0;
            int_pending     <= 1'b0;
        end else begin
            state_q         <= state_nxt;
            wait_cnt_q      <= wait_cnt_nxt;
            pc_lat_q        <= pc_lat_nxt;
            vec_ok_q        <= vec_ok_nxt;
            if_q            <= if_nxt;
            ie_out          <= ie_nxt;
            ime_out         <= ime_nxt;
            ei_pend_q       <= ei_pend_nxt;
            int_active_prio <= prio_nxt;
            push_req        <= push_req_nxt;
            push_data       <= push_data_nxt;
            pc_sel_ovr_en   <= pc_sel_ovr_en_nxt;
            pc_sel_ovr      <= pc_sel_ovr_nxt;
            dispatch_busy   <= (state_nxt != ST_IDLE);
            int_pending     <= |(ie_nxt[NUM_IRQ-1:0] & if_nxt);
        end
    end

endmodule

// File: doc/int_dispatch_ctrl.md
Name: int_dispatch_ctrl

Overview:
Interrupt controller and dispatch sequencer for the CPU core. Holds the IE, IF and IME state and resolves priority among the five interrupt sources. At an instruction boundary it takes control of the program-counter datapath to push the current PC and load the vector. It drives the PC module's pc_sel and int_active_prio, and handshakes 8-bit stack writes with the memory sequencer.

Parameters:
NUM_IRQ, 5, number of interrupt sources; bit 0 is the highest priority.
DISPATCH_WAIT, 2, idle cycles between accepting an interrupt and the first push.
PC_SEL_HOLD, 4'd0, pc_sel code that holds the PC.
PC_SEL_ZERO, 4'd4, pc_sel code that loads PC = 0x0000.
PC_SEL_INT, 4'd8, pc_sel code that loads PC = 0x40 + 8*prio.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
irq_in  in  5  interrupt source strobes; a 1 sets the matching IF bit
ie_wr  in  1  write reg_wdata into IE
if_wr  in  1  write reg_wdata[4:0] into IF
reg_wdata  in  8  register write data
ie_out  out  8  IE readback
if_out  out  8  IF readback; bits [7:5] always read 1
ei_exec  in  1  EI executed (1-cycle strobe)
di_exec  in  1  DI executed (1-cycle strobe)
reti_exec  in  1  RETI executed (1-cycle strobe)
instr_boundary  in  1  core is at an opcode-fetch boundary
pc_in  in  16  current PC from the PC module
push_req  out  1  stack byte write request
push_data  out  8  stack byte to write
push_ack  in  1  stack write accepted this cycle
pc_sel_ovr_en  out  1  controller owns pc_sel this cycle
pc_sel_ovr  out  4  pc_sel value presented to the PC module
int_active_prio  out  3  latched priority index, presented to the PC module
dispatch_busy  out  1  dispatch is in progress; core stalls fetch
int_pending  out  1  |(IE[4:0] & IF[4:0]), independent of IME (HALT wake)
ime_out  out  1  current IME value

Behaviour:
- Reset (async, reset==0):
  - IE = 0x00, IF[4:0] = 0, IME = 0, ei_pend = 0, state = IDLE.
  - All outputs are 0, except if_out = 0xE0.
- IF update each cycle:
  - Next IF = (if_wr ? reg_wdata[4:0] : IF) & ~clr_mask | irq_in.
  - A set from irq_in wins over both a register write and a dispatch clear on the same bit in the same cycle.
- IE update: loaded on ie_wr with all 8 bits stored; only bits [4:0] take part in requests.
- IME control:
  - di_exec: IME = 0 and ei_pend = 0 immediately.
  - ei_exec: ei_pend = 1; IME becomes 1 at the next instr_boundary after the one following EI, so one instruction runs before interrupts are enabled.
  - reti_exec: IME = 1 immediately.
  - di_exec wins over ei_exec or reti_exec in the same cycle.
- Request: req = IE[4:0] & IF[4:0]; prio = index of the lowest set bit of req.
- FSM states: IDLE, WAIT, PUSH_HI, PUSH_LO, JUMP.
  - IDLE: when instr_boundary & IME & |req:
    - latch prio into int_active_prio and pc_in into pc_lat;
    - clear IME and ei_pend; set wait counter = DISPATCH_WAIT-1;
    - go to WAIT.
  - WAIT: decrement the counter; at 0 go to PUSH_HI. DISPATCH_WAIT=0 goes straight to PUSH_HI.
  - PUSH_HI:
    - push_req = 1, push_data = pc_lat[15:8], held stable until push_ack.
    - On ack, re-sample req[int_active_prio] into vec_ok, then go to PUSH_LO.
  - PUSH_LO: push_req = 1, push_data = pc_lat[7:0]; on ack go to JUMP.
  - JUMP (exactly 1 cycle):
    - pc_sel_ovr_en = 1.
    - If vec_ok: pc_sel_ovr = PC_SEL_INT and clr_mask = 1<<int_active_prio.
    - Else (source cancelled by an IE/IF write during PUSH_HI): pc_sel_ovr = PC_SEL_ZERO and no IF bit is cleared.
    - Return to IDLE.
- dispatch_busy = (state != IDLE).
- Outside JUMP, pc_sel_ovr_en = 0 and pc_sel_ovr = PC_SEL_HOLD.
- The PC module resets its offset via the core's normal fetch path; this block does not drive offset_sel.
- A priority change after latching does not alter int_active_prio.
- A new irq_in during dispatch sets IF and is serviced only after IME is re-enabled.
- A push_ack held for multiple cycles in one state counts once per state.
- push_ack while push_req = 0 is ignored.
- Reset asserted mid-dispatch returns to IDLE asynchronously with push_req = 0. No partial push completes.

Decomposition:
- Shared package holds the pc_sel codes, the FSM state encoding, NUM_IRQ and the IF read-as-one mask 0xE0.
- One sub-module is natural: int_prio_enc (5-bit lowest-set-bit priority encoder plus a valid flag).

Test Plan:
- Reset, then read -> ie_out = 0x00, if_out = 0xE0, ime_out = 0, push_req = 0.
- IE = 0x05, irq_in = 0b00101, IME = 1, instr_boundary, pc_in = 0x1234 -> prio 0; WAIT 2 cycles; pushes 0x12 then 0x34; JUMP with pc_sel_ovr = 8, int_active_prio = 0; if_out = 0xE4.
- Same as the previous case, but IE written to 0x00 during PUSH_HI -> JUMP with pc_sel_ovr = 4; IF stays 0xE5.
- EI then a boundary with a pending request -> no dispatch on the first boundary; dispatch starts on the second.
- EI and DI in the same cycle -> IME stays 0 and no dispatch.
- push_ack withheld for 5 cycles in PUSH_HI -> push_data = pc_lat[15:8] stable throughout.
- irq_in bit 0 in the JUMP clear cycle -> IF bit 0 remains 1.
- Reset pulsed during PUSH_LO -> state = IDLE, IF = 0 (if_out = 0xE0), push_req drops.
